output_argmax: RTL
==================

# output_argmax

Sequential top-2 argmax classifier on the network's final-layer score vector. It captures the CLASS_NUM signed scores from the second (linear) layer in one valid/ready handshake, then scans them one class per cycle. It returns the winning class index, the winning score and the top1–top2 margin through an output valid/ready handshake. It sits directly downstream of the network's output layer and upstream of result reporting and readout logic.

## Interface
- DATA_WIDTH, 48: signed score width, equal to the output-layer accumulator width.
- CLASS_NUM, 10: number of classes; must be ≥ 2.
- IDX_WIDTH, $clog2(CLASS_NUM) (4): class index width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the score vector is valid.
- in_ready  out  1  the block can accept a vector; equals (state == IDLE).
- scores  in  signed [DATA_WIDTH-1:0] x [0:CLASS_NUM-1]  score vector; sampled only on the input handshake.
- out_valid  out  1  a result is available.
- out_ready  in  1  the consumer accepts the result.
- class_idx  out  [IDX_WIDTH-1:0]  index of the maximum score.
- top_score  out  signed [DATA_WIDTH-1:0]  maximum score.
- margin  out  unsigned [DATA_WIDTH:0]  top1 − top2; 0 on a tie.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready:
    - latch all scores into an internal array;
    - best ← scores[0], best_idx ← 0;
    - second ← most-negative DATA_WIDTH value (1 followed by zeros);
    - k ← 1;
    - go to SCAN.
- **SCAN**
  - Each cycle, let s = buf[k].
    - If s > best (strict signed compare): second ← best, best ← s, best_idx ← k.
    - Else if s > second: second ← s.
  - Strict compare means ties keep the lowest index.
  - k increments each cycle. When k == CLASS_NUM−1 has been processed, go to DONE.
  - On that same edge, load:
    - class_idx ← final best_idx;
    - top_score ← final best;
    - margin ← final best − final second, computed sign-extended to DATA_WIDTH+1 bits and always ≥ 0.
- **DONE**
  - out_valid = 1.
  - class_idx, top_score and margin are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid drops on the next cycle.
- in_valid while busy is not accepted; the upstream holds its vector.
- The score input is not used after capture, so the upstream may change scores freely after the handshake.
- Reset values:
  - state = IDLE, so in_ready = 1 even while rst_n is low;
  - out_valid = 0, busy = 0;
  - class_idx = 0, top_score = 0, margin = 0;
  - internal buffer, k, best and second cleared.
- Reset asserted mid-SCAN or in DONE: the result is discarded immediately, with no output handshake. The block accepts a new vector in the first cycle after rst_n deasserts.

## Timing
- Input handshake in cycle T.
- SCAN occupies cycles T+1 … T+CLASS_NUM−1.
- out_valid is first high in cycle T+CLASS_NUM (T+10 at default parameters).
- If out_ready is already high: output handshake in T+CLASS_NUM, IDLE in T+CLASS_NUM+1.
- Maximum throughput: one vector per CLASS_NUM+1 cycles.
- Output stall: out_valid and all result fields stay constant for every cycle out_ready is low. There is no timeout.
- Outputs are registered. in_ready and busy are decoded directly from the state register.

## Structure
- Shared package nn_pkg holds:
  - the CLASS_NUM and SCORE_WIDTH (48) constants;
  - typedef score_t (logic signed [SCORE_WIDTH-1:0]);
  - typedef argmax_state_e {IDLE, SCAN, DONE};
  - the SCORE_MIN constant.
- One sub-module, top2_update (purely combinational): inputs best, second, best_idx, s, k; outputs the next best, second and best_idx. This isolates the compare and tie rule so it can be unit-tested.
- Everything else (FSM, buffer, counter, output registers) lives in output_argmax.

## Test plan
- Distinct maximum, scores = {5,−3,12,7,0,1,2,3,4,−9}, out_ready = 1 → class_idx = 2, top_score = 12, margin = 5, out_valid first high exactly 10 cycles after accept.
- Tie, all scores = −4 → class_idx = 0, top_score = −4, margin = 0. Scores[3] = scores[8] = 100, others 0 → class_idx = 3, margin = 0.
- Extremes: scores[9] = 2^47−1, others = −2^47 → class_idx = 9, margin = 2^48−1, with no overflow into the sign.
- Backpressure: out_ready low for 20 cycles after out_valid → outputs constant, in_ready = 0, a new in_valid is not accepted. Raise out_ready → handshake, then in_ready = 1 on the next cycle.
- Reset mid-SCAN, rst_n low at T+4 → out_valid stays 0, all outputs 0. A fresh vector after release gives a correct result 10 cycles later.
- Back-to-back: in_valid held high with 3 vectors, out_ready = 1 → three results, accepts spaced exactly 11 cycles apart, each result matching a reference model.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the network output stage.
// Score width matches the output-layer accumulator width.
package nn_pkg;

    localparam int unsigned CLASS_NUM   = 10;
    localparam int unsigned SCORE_WIDTH = 48;
    localparam int unsigned IDX_WIDTH   = $clog2(CLASS_NUM);

    typedef logic signed [SCORE_WIDTH-1:0] score_t;
    typedef logic [IDX_WIDTH-1:0]          class_idx_t;
    typedef logic [SCORE_WIDTH:0]          margin_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_e;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_WIDTH - 1){1'b0}}};

endpackage

// File: rtl/output_argmax_if.sv
// Score-vector input and classification-result output handshakes of output_argmax.
// master is the upstream/consumer side, slave is the classifier.
interface output_argmax_if;
    import nn_pkg::*;

    logic       in_valid;
    logic       in_ready;
    score_t     scores [CLASS_NUM];
    logic       out_valid;
    logic       out_ready;
    class_idx_t class_idx;
    score_t     top_score;
    margin_t    margin;
    logic       busy;

    modport master (
        output in_valid,
        output scores,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  class_idx,
        input  top_score,
        input  margin,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  scores,
        input  out_ready,
        output in_ready,
        output out_valid,
        output class_idx,
        output top_score,
        output margin,
        output busy
    );

endinterface

// File: rtl/top2_update.sv
// One step of the running top-2 search: folds score s (class k) into best/second.
// Strict compares keep the lowest index on ties.
module top2_update
    import nn_pkg::*;
(
    input  score_t     best,
    input  score_t     second,
    input  class_idx_t best_idx,
    input  score_t     s,
    input  class_idx_t k,
    output score_t     best_nxt,
    output score_t     second_nxt,
    output class_idx_t best_idx_nxt
);

    always_comb begin
        best_nxt     = best;
        second_nxt   = second;
        best_idx_nxt = best_idx;
        if (s > best) begin
            second_nxt   = best;
            best_nxt     = s;
            best_idx_nxt = k;
        end else if (s > second) begin
            second_nxt = s;
        end
    end

endmodule

// File: rtl/output_argmax.sv
// Sequential top-2 argmax: captures a score vector, scans one class per cycle,
// then presents class index, top score and top1-top2 margin until accepted.
module output_argmax
    import nn_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    output_argmax_if.slave  bus
);

    localparam class_idx_t K_LAST = class_idx_t'(CLASS_NUM - 1);

    argmax_state_e state_q, state_d;
    score_t        score_buf_q [CLASS_NUM];
    score_t        score_buf_d [CLASS_NUM];
    class_idx_t    k_q, k_d;
    score_t        best_q, best_d;
    score_t        second_q, second_d;
    class_idx_t    best_idx_q, best_idx_d;
    class_idx_t    class_idx_q, class_idx_d;
    score_t        top_score_q, top_score_d;
    margin_t       margin_q, margin_d;

    score_t        upd_best;
    score_t        upd_second;
    class_idx_t    upd_idx;

    top2_update u_top2_update (
        .best         (best_q),
        .second       (second_q),
        .best_idx     (best_idx_q),
        .s            (score_buf_q[k_q]),
        .k            (k_q),
        .best_nxt     (upd_best),
        .second_nxt   (upd_second),
        .best_idx_nxt (upd_idx)
    );

    always_comb begin
        state_d     = state_q;
        score_buf_d = score_buf_q;
        k_d         = k_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        top_score_d = top_score_q;
        margin_d    = margin_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    score_buf_d = bus.scores;
                    best_d      = bus.scores[0];
                    best_idx_d  = '0;
                    second_d    = SCORE_MIN;
                    k_d         = class_idx_t'(1);
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                best_d     = upd_best;
                second_d   = upd_second;
                best_idx_d = upd_idx;
                k_d        = k_q + class_idx_t'(1);
                if (k_q == K_LAST) begin
                    state_d     = DONE;
                    class_idx_d = upd_idx;
                    top_score_d = upd_best;
                    // One extra bit so best - SCORE_MIN cannot wrap into the sign.
                    margin_d    = {upd_best[SCORE_WIDTH-1], upd_best}
                                - {upd_second[SCORE_WIDTH-1], upd_second};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            best_q      <= '0;
            second_q    <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            top_score_q <= '0;
            margin_q    <= '0;
            for (int i = 0; i < CLASS_NUM; i++) begin
                score_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            best_q      <= best_d;
            second_q    <= second_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            top_score_q <= top_score_d;
            margin_q    <= margin_d;
            score_buf_q <= score_buf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.class_idx = class_idx_q;
    assign bus.top_score = top_score_q;
    assign bus.margin    = margin_q;

endmodule
